// File: rtl/alu_control_sequencer.sv
// Hardwired control sequencer for register-register ALU instructions.
// Steps fetch T0-T2 and execute T3-T6, decoding IR into Datapath strobes.
module alu_control_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [31:0]      ir,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic [15:0]      Rout,
    output logic [15:0]      Rin,
    output logic             HIin,
    output logic             LOin,
    output logic [4:0]       opcode,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       cls_a, cls_m, cls_u, cls_ill;
    logic       unused_ir;

    assign op        = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign cls_a   = (op >= 5'd3) && (op <= 5'd11);
    assign cls_m   = (op == 5'd15) || (op == 5'd16);
    assign cls_u   = (op == 5'd17) || (op == 5'd18);
    assign cls_ill = !(cls_a || cls_m || cls_u);

    function automatic logic [15:0] sel(input logic [3:0] idx);
        sel = 16'd1 << idx;
    endfunction

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Rout     = 16'h0000;
        Rin      = 16'h0000;
        HIin     = 1'b0;
        LOin     = 1'b0;
        opcode   = 5'd0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = T0;
            end
            T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = T1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = T2;
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                if (cls_ill) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    Rout    = sel(rb);
                    Yin     = 1'b1;
                    state_d = T4;
                end
            end
            T4: begin
                // Unary ops take their single operand from Rb twice.
                Rout    = cls_u ? sel(rb) : sel(rc);
                Zin     = 1'b1;
                opcode  = op;
                state_d = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (cls_m) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    Rin     = sel(ra);
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign illegal = illegal_q || ((state_q == T3) && cls_ill);
    assign instr_count = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (done && (state_q != T3)) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if ((state_q == IDLE) && start) illegal_q <= 1'b0;
            else if ((state_q == T3) && cls_ill) illegal_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed testbench for alu_control_sequencer.
// A second narrow-counter instance shares stimulus to exercise wrap-around.
module tb_alu_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, start;
    logic [31:0] ir;

    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin;
    logic Yin, Zlowout, Zhighout, HIin, LOin, busy, done, illegal;
    logic [15:0] Rout, Rin;
    logic [4:0]  opcode;
    logic [15:0] instr_count;

    logic n_PCout, n_MARin, n_IncPC, n_Zin, n_PCin, n_Read, n_MDRin;
    logic n_MDRout, n_IRin, n_Yin, n_Zlowout, n_Zhighout, n_HIin, n_LOin;
    logic n_busy, n_done, n_illegal;
    logic [15:0] n_Rout, n_Rin;
    logic [4:0]  n_opcode;
    logic [1:0]  n_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_control_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
        .IRin(IRin), .Yin(Yin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .Rout(Rout), .Rin(Rin), .HIin(HIin), .LOin(LOin),
        .opcode(opcode), .busy(busy), .done(done), .illegal(illegal),
        .instr_count(instr_count)
    );

    alu_control_sequencer #(.CNT_W(2)) dut_n (
        .clock(clock), .clear(clear), .start(start), .ir(ir),
        .PCout(n_PCout), .MARin(n_MARin), .IncPC(n_IncPC), .Zin(n_Zin),
        .PCin(n_PCin), .Read(n_Read), .MDRin(n_MDRin), .MDRout(n_MDRout),
        .IRin(n_IRin), .Yin(n_Yin), .Zlowout(n_Zlowout),
        .Zhighout(n_Zhighout), .Rout(n_Rout), .Rin(n_Rin),
        .HIin(n_HIin), .LOin(n_LOin), .opcode(n_opcode), .busy(n_busy),
        .done(n_done), .illegal(n_illegal), .instr_count(n_count)
    );

    localparam logic [15:0] PCO = 16'h8000, MAR = 16'h4000;
    localparam logic [15:0] INC = 16'h2000, ZI  = 16'h1000;
    localparam logic [15:0] PCI = 16'h0800, RD  = 16'h0400;
    localparam logic [15:0] MDI = 16'h0200, MDO = 16'h0100;
    localparam logic [15:0] IRI = 16'h0080, YI  = 16'h0040;
    localparam logic [15:0] ZLO = 16'h0020, ZHI = 16'h0010;
    localparam logic [15:0] HII = 16'h0008, LOI = 16'h0004;
    localparam logic [15:0] BSY = 16'h0002, DN  = 16'h0001;

    logic [15:0] strb;
    assign strb = {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
                   IRin, Yin, Zlowout, Zhighout, HIin, LOin, busy, done};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [15:0] s,
                       input logic [15:0] ro, input logic [15:0] ri,
                       input logic [4:0] op);
        chk({tag, ".strb"}, 32'(strb), 32'(s));
        chk({tag, ".rout"}, 32'(Rout), 32'(ro));
        chk({tag, ".rin"}, 32'(Rin), 32'(ri));
        chk({tag, ".op"}, 32'(opcode), 32'(op));
    endtask

    task automatic fetch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc({tag, ".t0"}, PCO | MAR | INC | ZI | BSY, 16'h0, 16'h0, 5'd0);
        tick();
        cyc({tag, ".t1"}, ZLO | PCI | RD | MDI | BSY, 16'h0, 16'h0, 5'd0);
        tick();
        cyc({tag, ".t2"}, MDO | IRI | BSY, 16'h0, 16'h0, 5'd0);
        tick();
    endtask

    initial begin
        clear = 1'b1;
        start = 1'b0;
        ir    = 32'h0;
        tick();
        clear = 1'b0;
        cyc("rst", 16'h0, 16'h0, 16'h0, 5'd0);
        chk("rst.cnt", 32'(instr_count), 32'd0);
        chk("rst.ill", 32'(illegal), 32'd0);

        // sub R1,R2,R3
        ir = 32'h20918000;
        fetch("sub");
        cyc("sub.t3", YI | BSY, 16'h0004, 16'h0, 5'd0);
        tick();
        cyc("sub.t4", ZI | BSY, 16'h0008, 16'h0, 5'd4);
        tick();
        cyc("sub.t5", ZLO | BSY | DN, 16'h0, 16'h0002, 5'd0);
        tick();
        cyc("sub.idle", 16'h0, 16'h0, 16'h0, 5'd0);
        chk("sub.cnt", 32'(instr_count), 32'd1);

        // mul R4,R5
        ir = 32'h78228000;
        fetch("mul");
        cyc("mul.t3", YI | BSY, 16'h0010, 16'h0, 5'd0);
        tick();
        cyc("mul.t4", ZI | BSY, 16'h0020, 16'h0, 5'd15);
        tick();
        cyc("mul.t5", ZLO | LOI | BSY, 16'h0, 16'h0, 5'd0);
        tick();
        cyc("mul.t6", ZHI | HII | BSY | DN, 16'h0, 16'h0, 5'd0);
        tick();
        cyc("mul.idle", 16'h0, 16'h0, 16'h0, 5'd0);
        chk("mul.cnt", 32'(instr_count), 32'd2);

        // illegal opcode 11111
        ir = 32'hF8000000;
        fetch("ill");
        cyc("ill.t3", BSY | DN, 16'h0, 16'h0, 5'd0);
        chk("ill.flag3", 32'(illegal), 32'd1);
        tick();
        cyc("ill.idle", 16'h0, 16'h0, 16'h0, 5'd0);
        chk("ill.sticky", 32'(illegal), 32'd1);
        chk("ill.cnt", 32'(instr_count), 32'd2);

        // unary op 10001, Ra=3 Rb=6; its start clears illegal
        ir = 32'h89B00000;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("un.illclr", 32'(illegal), 32'd0);
        tick();
        tick();
        tick();
        cyc("un.t3", YI | BSY, 16'h0040, 16'h0, 5'd0);
        tick();
        cyc("un.t4", ZI | BSY, 16'h0040, 16'h0, 5'd17);
        tick();
        cyc("un.t5", ZLO | BSY | DN, 16'h0, 16'h0008, 5'd0);
        tick();
        chk("un.cnt", 32'(instr_count), 32'd3);
        chk("un.ncnt", 32'(n_count), 32'd3);

        // clear during T4 abandons the instruction
        ir = 32'h20918000;
        fetch("clr");
        tick();
        chk("clr.inT4", 32'(opcode), 32'd4);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cyc("clr.idle", 16'h0, 16'h0, 16'h0, 5'd0);
        chk("clr.cnt", 32'(instr_count), 32'd0);
        chk("clr.ncnt", 32'(n_count), 32'd0);
        tick();
        chk("clr.stay", 32'(busy), 32'd0);

        // add R7,R7,R7 back-to-back with start held high
        ir = 32'h1BBB8000;
        start = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 6)
                cyc("b2b.t5", ZLO | BSY | DN, 16'h0, 16'h0080, 5'd0);
            if (i == 7) chk("b2b.idle", 32'(strb), 32'd0);
            if (i == 8) chk("b2b.t0", 32'(strb), 32'(PCO | MAR | INC | ZI | BSY));
            if (i == 10) chk("b2b.cnt1", 32'(instr_count), 32'd1);
        end
        start = 1'b0;
        chk("b2b.end", 32'(busy), 32'd0);
        chk("b2b.cnt", 32'(instr_count), 32'd3);
        chk("b2b.ncnt", 32'(n_count), 32'd3);

        // fourth instruction with a stray start while busy; narrow count wraps
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign.t2", 32'(strb), 32'(MDO | IRI | BSY));
        for (int i = 0; i < 4; i++) tick();
        chk("ign.idle", 32'(busy), 32'd0);
        tick();
        chk("ign.stay", 32'(busy), 32'd0);
        chk("wrap.cnt", 32'(instr_count), 32'd4);
        chk("wrap.ncnt", 32'(n_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
